// File: rtl/eu_mdu_arbiter.sv
// eu_mdu_arbiter: shares one multi-cycle multiply/divide unit between the two
// execution-unit ways. Round-robin grant, operand latch, start/done sequencing,
// a watchdog on hung operations, and a held writeback result.
module eu_mdu_arbiter #(
    parameter int MAX_CYCLES = 72,
    parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,

    input  logic        way0_req_i,
    input  logic [3:0]  way0_op_i,
    input  logic [63:0] way0_rs1_i,
    input  logic [63:0] way0_rs2_i,
    input  logic [4:0]  way0_rdAddr_i,
    input  logic [1:0]  way0_pID_i,
    output logic        way0_stall_o,

    input  logic        way1_req_i,
    input  logic [3:0]  way1_op_i,
    input  logic [63:0] way1_rs1_i,
    input  logic [63:0] way1_rs2_i,
    input  logic [4:0]  way1_rdAddr_i,
    input  logic [1:0]  way1_pID_i,
    output logic        way1_stall_o,

    output logic        mdu_start_o,
    output logic [3:0]  mdu_op_o,
    output logic [63:0] mdu_rs1_o,
    output logic [63:0] mdu_rs2_o,
    input  logic        mdu_done_i,
    input  logic [63:0] mdu_result_i,
    output logic        mdu_flush_o,

    output logic        wb_valid_o,
    output logic        wb_way_o,
    output logic [4:0]  wb_rdAddr_o,
    output logic [1:0]  wb_pID_o,
    output logic [63:0] wb_data_o,
    output logic        wb_err_o,
    input  logic        wb_ready_i,

    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic               rr;        // 0: way0 wins a tie, 1: way1 wins
    logic [1:0]         mask;      // one-cycle cooldown after a handshake
    logic [CNT_W-1:0]   cnt;

    logic               elig0, elig1;
    logic               grant_vld, grant_way;
    logic               done_hit, wd_fire, handshake;

    assign elig0     = way0_req_i & ~mask[0];
    assign elig1     = way1_req_i & ~mask[1];
    assign grant_vld = (state == IDLE) & (elig0 | elig1) & ~flush_i;
    assign grant_way = (elig0 & elig1) ? rr : elig1;
    assign done_hit  = (state == WAIT) & mdu_done_i;
    // done has priority over the watchdog when both land together
    assign wd_fire   = (state == WAIT) & ~mdu_done_i & (cnt == CNT_W'(MAX_CYCLES - 1));
    assign handshake = (state == RESP) & wb_ready_i;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (grant_vld)            state_nxt = START;
            START:                           state_nxt = WAIT;
            WAIT:  if (done_hit || wd_fire)  state_nxt = RESP;
            RESP:  if (handshake)            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    // Combinational outputs: pulses, writeback valid and way stalls
    always_comb begin
        mdu_start_o  = (state == START);
        timeout_o    = wd_fire & ~flush_i;
        mdu_flush_o  = (flush_i & ((state == START) | (state == WAIT))) | (wd_fire & ~flush_i);
        wb_valid_o   = (state == RESP) & ~flush_i;
        way0_stall_o = way0_req_i & ~(handshake & (wb_way_o == 1'b0));
        way1_stall_o = way1_req_i & ~(handshake & (wb_way_o == 1'b1));
    end

    // Datapath: grant latch, round-robin pointer, watchdog counter, result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            rr          <= 1'b0;
            mask        <= 2'b00;
            cnt         <= '0;
            mdu_op_o    <= '0;
            mdu_rs1_o   <= '0;
            mdu_rs2_o   <= '0;
            wb_way_o    <= 1'b0;
            wb_rdAddr_o <= '0;
            wb_pID_o    <= '0;
            wb_data_o   <= '0;
            wb_err_o    <= 1'b0;
        end else begin
            if (grant_vld) begin
                rr          <= ~grant_way;
                wb_way_o    <= grant_way;
                mdu_op_o    <= grant_way ? way1_op_i     : way0_op_i;
                mdu_rs1_o   <= grant_way ? way1_rs1_i    : way0_rs1_i;
                mdu_rs2_o   <= grant_way ? way1_rs2_i    : way0_rs2_i;
                wb_rdAddr_o <= grant_way ? way1_rdAddr_i : way0_rdAddr_i;
                wb_pID_o    <= grant_way ? way1_pID_i    : way0_pID_i;
            end

            if (state == START)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;

            if (done_hit) begin
                wb_data_o <= mdu_result_i;
                wb_err_o  <= 1'b0;
            end else if (wd_fire) begin
                wb_data_o <= '0;
                wb_err_o  <= 1'b1;
            end

            // The served way's request is stale for one cycle after its
            // handshake because the EU register's ready is registered.
            mask <= 2'b00;
            if (handshake && !flush_i) mask[wb_way_o] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eu_mdu_arbiter.sv
// Directed bench for eu_mdu_arbiter with hand-computed expectations.
module tb_eu_mdu_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush_i;
    logic        way0_req_i, way1_req_i;
    logic [3:0]  way0_op_i, way1_op_i;
    logic [63:0] way0_rs1_i, way0_rs2_i, way1_rs1_i, way1_rs2_i;
    logic [4:0]  way0_rdAddr_i, way1_rdAddr_i;
    logic [1:0]  way0_pID_i, way1_pID_i;
    logic        way0_stall_o, way1_stall_o;
    logic        mdu_start_o, mdu_done_i, mdu_flush_o;
    logic [3:0]  mdu_op_o;
    logic [63:0] mdu_rs1_o, mdu_rs2_o, mdu_result_i;
    logic        wb_valid_o, wb_way_o, wb_err_o, wb_ready_i, timeout_o;
    logic [4:0]  wb_rdAddr_o;
    logic [1:0]  wb_pID_o;
    logic [63:0] wb_data_o;

    int nvec = 0;
    int nerr = 0;

    eu_mdu_arbiter #(.MAX_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .way0_req_i(way0_req_i), .way0_op_i(way0_op_i), .way0_rs1_i(way0_rs1_i),
        .way0_rs2_i(way0_rs2_i), .way0_rdAddr_i(way0_rdAddr_i), .way0_pID_i(way0_pID_i),
        .way0_stall_o(way0_stall_o),
        .way1_req_i(way1_req_i), .way1_op_i(way1_op_i), .way1_rs1_i(way1_rs1_i),
        .way1_rs2_i(way1_rs2_i), .way1_rdAddr_i(way1_rdAddr_i), .way1_pID_i(way1_pID_i),
        .way1_stall_o(way1_stall_o),
        .mdu_start_o(mdu_start_o), .mdu_op_o(mdu_op_o), .mdu_rs1_o(mdu_rs1_o),
        .mdu_rs2_o(mdu_rs2_o), .mdu_done_i(mdu_done_i), .mdu_result_i(mdu_result_i),
        .mdu_flush_o(mdu_flush_o),
        .wb_valid_o(wb_valid_o), .wb_way_o(wb_way_o), .wb_rdAddr_o(wb_rdAddr_o),
        .wb_pID_o(wb_pID_o), .wb_data_o(wb_data_o), .wb_err_o(wb_err_o),
        .wb_ready_i(wb_ready_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, want finish before 100000");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd, input logic [1:0] pid);
        way0_req_i = 1'b1; way0_op_i = 4'b0000; way0_rs1_i = a; way0_rs2_i = b;
        way0_rdAddr_i = rd; way0_pID_i = pid;
    endtask

    task automatic req1(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd, input logic [1:0] pid);
        way1_req_i = 1'b1; way1_op_i = 4'b1001; way1_rs1_i = a; way1_rs2_i = b;
        way1_rdAddr_i = rd; way1_pID_i = pid;
    endtask

    // Entered in the START cycle; returns in the cycle after the handshake.
    task automatic serve(input logic w, input logic [63:0] rs1, input logic [4:0] rd,
                         input int dly, input logic [63:0] res, input int bp);
        chk("start", mdu_start_o, 1);
        chk("mdu_rs1", mdu_rs1_o, rs1);
        cyc;
        chk("start_one_cycle", mdu_start_o, 0);
        repeat (dly - 1) cyc;
        mdu_done_i = 1'b1; mdu_result_i = res;
        cyc;
        mdu_done_i = 1'b0; mdu_result_i = '0;
        #1;
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", wb_valid_o, 1);
            chk("bp_data", wb_data_o, res);
            chk("bp_rd", wb_rdAddr_o, rd);
            chk("bp_stall", w ? way1_stall_o : way0_stall_o, 1);
            cyc;
        end
        wb_ready_i = 1'b1;
        #1;
        chk("wb_valid", wb_valid_o, 1);
        chk("wb_data", wb_data_o, res);
        chk("wb_way", wb_way_o, w);
        chk("wb_rd", wb_rdAddr_o, rd);
        chk("wb_err", wb_err_o, 0);
        chk("hs_stall", w ? way1_stall_o : way0_stall_o, 0);
        cyc;
        wb_ready_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0;
        mdu_done_i = 1'b0; mdu_result_i = '0;
        way0_req_i = 1'b0; way0_op_i = '0; way0_rs1_i = '0; way0_rs2_i = '0;
        way0_rdAddr_i = '0; way0_pID_i = '0;
        way1_req_i = 1'b0; way1_op_i = '0; way1_rs1_i = '0; way1_rs2_i = '0;
        way1_rdAddr_i = '0; way1_pID_i = '0;
        repeat (2) cyc;

        // reset state; stall follows req even in reset
        way0_req_i = 1'b1;
        #1;
        chk("rst_valid", wb_valid_o, 0);
        chk("rst_start", mdu_start_o, 0);
        chk("rst_flush", mdu_flush_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_data", wb_data_o, 0);
        chk("rst_stall0", way0_stall_o, 1);
        chk("rst_stall1", way1_stall_o, 0);
        cyc;
        way0_req_i = 1'b0;
        reset = 1'b0;
        cyc;

        // single request MUL 7*6 with cooldown on a held stale request
        req0(64'd7, 64'd6, 5'd5, 2'd1);
        #1;
        chk("t_stall0", way0_stall_o, 1);
        chk("t_start", mdu_start_o, 0);
        cyc;
        chk("mdu_op", mdu_op_o, 4'b0000);
        chk("mdu_rs2", mdu_rs2_o, 64'd6);
        serve(1'b0, 64'd7, 5'd5, 3, 64'd42, 0);
        chk("wb_pid", wb_pID_o, 2'd1);
        chk("cool_stall0", way0_stall_o, 1);
        chk("cool_valid", wb_valid_o, 0);
        cyc;
        way0_req_i = 1'b0;
        #1;
        chk("cool_no_grant", mdu_start_o, 0);
        chk("cool_stall_drop", way0_stall_o, 0);
        cyc;

        // simultaneous requests from reset, then a repeat
        reset = 1'b1; cyc; reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            req0(64'd100 + r, 64'd3, 5'd1, 2'd0);
            req1(64'd200 + r, 64'd4, 5'd2, 2'd1);
            cyc;
            serve(1'b0, 64'd100 + r, 5'd1, 1, 64'd1000 + r, 0);
            way0_req_i = 1'b0;
            cyc;
            chk("sim_op1", mdu_op_o, 4'b1001);
            serve(1'b1, 64'd200 + r, 5'd2, 2, 64'd2000 + r, 0);
            way1_req_i = 1'b0;
            cyc;
        end

        // backpressure on way0, then a tie goes to way1 via the pointer
        req0(64'd300, 64'd1, 5'd3, 2'd2);
        cyc;
        serve(1'b0, 64'd300, 5'd3, 1, 64'd3000, 5);
        way0_req_i = 1'b0;
        cyc;
        req0(64'd301, 64'd1, 5'd3, 2'd2);
        req1(64'd400, 64'd1, 5'd4, 2'd3);
        cyc;
        serve(1'b1, 64'd400, 5'd4, 1, 64'd4000, 0);
        way1_req_i = 1'b0;
        cyc;
        serve(1'b0, 64'd301, 5'd3, 2, 64'd3001, 0);
        way0_req_i = 1'b0;
        cyc;

        // watchdog: done never arrives
        req1(64'd500, 64'd0, 5'd7, 2'd0);
        cyc;
        chk("wd_start", mdu_start_o, 1);
        cyc;
        for (int k = 1; k <= 8; k++) begin
            chk("wd_flush", mdu_flush_o, (k == 8));
            chk("wd_timeout", timeout_o, (k == 8));
            cyc;
        end
        chk("wd_valid", wb_valid_o, 1);
        chk("wd_data", wb_data_o, 0);
        chk("wd_err", wb_err_o, 1);
        chk("wd_way", wb_way_o, 1);
        chk("wd_rd", wb_rdAddr_o, 5'd7);
        chk("wd_flush_once", mdu_flush_o, 0);
        wb_ready_i = 1'b1;
        cyc;
        wb_ready_i = 1'b0;
        way1_req_i = 1'b0;
        cyc;

        // flush in WAIT cycle 2, late done ignored
        req0(64'd600, 64'd2, 5'd9, 2'd1);
        cyc;
        cyc;
        chk("fl_wait1", mdu_flush_o, 0);
        cyc;
        flush_i = 1'b1;
        #1;
        chk("fl_flush", mdu_flush_o, 1);
        chk("fl_timeout", timeout_o, 0);
        cyc;
        flush_i = 1'b0;
        way0_req_i = 1'b0;
        #1;
        chk("fl_idle_start", mdu_start_o, 0);
        chk("fl_valid", wb_valid_o, 0);
        cyc;
        mdu_done_i = 1'b1; mdu_result_i = 64'd99;
        cyc;
        mdu_done_i = 1'b0; mdu_result_i = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fl_late_done", wb_valid_o, 0);
            cyc;
        end

        // recovery after flush and timeout: normal op clears the error flag
        req1(64'd700, 64'd5, 5'd11, 2'd2);
        cyc;
        serve(1'b1, 64'd700, 5'd11, 1, 64'd7777, 0);
        way1_req_i = 1'b0;
        cyc;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
